// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause 22 MDIO responder.
package mdio_pkg;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    typedef enum logic [2:0] {
        PRE,
        ST,
        OP,
        ADDR,
        TA,
        DATA
    } mdio_state_e;

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronizers for MDC/MDIO plus MDC rising-edge detection.
module mdio_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_rise,
    output logic o_mdio
);

    logic r_mdc_s1;
    logic r_mdc_s2;
    logic r_mdc_prev;
    logic r_mdio_s1;
    logic r_mdio_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mdc_s1   <= 1'b0;
            r_mdc_s2   <= 1'b0;
            r_mdc_prev <= 1'b0;
            r_mdio_s1  <= 1'b0;
            r_mdio_s2  <= 1'b0;
        end else begin
            r_mdc_s1   <= i_mdc;
            r_mdc_s2   <= r_mdc_s1;
            r_mdc_prev <= r_mdc_s2;
            r_mdio_s1  <= i_mdio;
            r_mdio_s2  <= r_mdio_s1;
        end
    end

    assign o_rise = r_mdc_s2 & ~r_mdc_prev;
    assign o_mdio = r_mdio_s2;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO responder: frame decode, register strobes, read drive.
// Optional MDIO_BCAST_EN: PHYAD 0 also matches write frames (broadcast write).
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
    parameter int                 PREAMBLE_LEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_mdc,
    input  logic               i_mdio,
    output logic               o_mdio_out,
    output logic               o_mdio_oe,
    output logic [REGAD_W-1:0] o_reg_addr,
    output logic               o_reg_wr,
    output logic [DATA_W-1:0]  o_reg_wdata,
    output logic               o_reg_rd,
    input  logic [DATA_W-1:0]  i_reg_rdata,
    output logic               o_busy
);

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_LEN);

    logic        w_rise;
    logic        w_mdio;
    logic [9:0]  w_addr_word;
    logic [1:0]  w_op;
    logic        w_match;

    mdio_state_e r_state;
    logic [5:0]  r_ones;
    logic [3:0]  r_bitcnt;
    logic        r_op_msb;
    logic        r_is_read;
    logic        r_match;
    logic        r_rd_d;
    logic [DATA_W-1:0] r_shift;

    mdio_edge_sync u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_mdc  (i_mdc),
        .i_mdio (i_mdio),
        .o_rise (w_rise),
        .o_mdio (w_mdio)
    );

    assign w_addr_word = {r_shift[8:0], w_mdio};
    assign w_op        = {r_op_msb, w_mdio};

    // Reads only ever match our own address; broadcast applies to writes alone.
    always_comb begin
        w_match = (w_addr_word[9:5] == PHY_ADDR);
`ifdef MDIO_BCAST_EN
        if (!r_is_read && (w_addr_word[9:5] == '0))
            w_match = 1'b1;
`else
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= PRE;
            r_ones      <= '0;
            r_bitcnt    <= '0;
            r_op_msb    <= 1'b0;
            r_is_read   <= 1'b0;
            r_match     <= 1'b0;
            r_rd_d      <= 1'b0;
            r_shift     <= '0;
            o_mdio_out  <= 1'b0;
            o_mdio_oe   <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wr    <= 1'b0;
            o_reg_wdata <= '0;
            o_reg_rd    <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_reg_wr <= 1'b0;
            o_reg_rd <= 1'b0;
            r_rd_d   <= o_reg_rd;
            // Read data arrives one cycle after the strobe, long before the next MDC edge.
            if (r_rd_d)
                r_shift <= i_reg_rdata;

            if (w_rise) begin
                case (r_state)
                    PRE: begin
                        if (w_mdio) begin
                            if (r_ones != 6'd32)
                                r_ones <= r_ones + 6'd1;
                        end else if (r_ones >= PRE_MIN) begin
                            r_state <= ST;
                            r_ones  <= '0;
                        end else begin
                            r_ones <= '0;
                        end
                    end
                    ST: begin
                        if (w_mdio) begin
                            r_state  <= OP;
                            o_busy   <= 1'b1;
                            r_bitcnt <= '0;
                        end else begin
                            r_state <= PRE;
                        end
                    end
                    OP: begin
                        if (r_bitcnt == 4'd0) begin
                            r_op_msb <= w_mdio;
                            r_bitcnt <= 4'd1;
                        end else begin
                            r_bitcnt <= '0;
                            if ((w_op == OP_READ) || (w_op == OP_WRITE)) begin
                                r_state   <= ADDR;
                                r_is_read <= (w_op == OP_READ);
                            end else begin
                                r_state <= PRE;
                                o_busy  <= 1'b0;
                            end
                        end
                    end
                    ADDR: begin
                        r_shift <= {r_shift[DATA_W-2:0], w_mdio};
                        if (r_bitcnt == 4'd9) begin
                            r_bitcnt   <= '0;
                            r_state    <= TA;
                            o_reg_addr <= w_addr_word[REGAD_W-1:0];
                            r_match    <= w_match;
                            if (r_is_read && w_match)
                                o_reg_rd <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    TA: begin
                        if (r_bitcnt == 4'd0) begin
                            r_bitcnt <= 4'd1;
                            if (r_is_read && r_match) begin
                                o_mdio_out <= 1'b0;
                                o_mdio_oe  <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= '0;
                            r_state  <= DATA;
                            if (r_is_read && r_match) begin
                                o_mdio_out <= r_shift[DATA_W-1];
                                r_shift    <= {r_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    DATA: begin
                        if (r_is_read) begin
                            if (r_bitcnt == 4'd15) begin
                                o_mdio_oe  <= 1'b0;
                                o_mdio_out <= 1'b0;
                            end else if (r_match) begin
                                o_mdio_out <= r_shift[DATA_W-1];
                                r_shift    <= {r_shift[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            r_shift <= {r_shift[DATA_W-2:0], w_mdio};
                        end
                        if (r_bitcnt == 4'd15) begin
                            r_bitcnt <= '0;
                            r_state  <= PRE;
                            r_ones   <= '0;
                            o_busy   <= 1'b0;
                            if (!r_is_read && r_match) begin
                                o_reg_wdata <= {r_shift[DATA_W-2:0], w_mdio};
                                o_reg_wr    <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    default: r_state <= PRE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: station-side MDC/MDIO driver, register model, strobe monitor.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        mdio;
    logic        out;
    logic        oe;
    logic [4:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic        rd;
    logic [15:0] rdata = '0;
    logic        busy;

    logic [15:0] regs [32];

    int n_checks = 0;
    int n_pass   = 0;

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          oe_cycles = 0;
    int          both_cnt = 0;
    int          long_cnt = 0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;

    logic s_out;
    logic s_oe;
    logic s_busy;

    always #5 clk = ~clk;

    mdio_responder #(
        .PHY_ADDR     (5'd1),
        .PREAMBLE_LEN (32)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mdc       (mdc),
        .i_mdio      (mdio),
        .o_mdio_out  (out),
        .o_mdio_oe   (oe),
        .o_reg_addr  (addr),
        .o_reg_wr    (wr),
        .o_reg_wdata (wdata),
        .o_reg_rd    (rd),
        .i_reg_rdata (rdata),
        .o_busy      (busy)
    );

    // Register block model: read data is valid exactly one clock after the strobe.
    always @(posedge clk) begin
        if (rd)
            rdata <= regs[addr];
    end

    always @(negedge clk) begin
        if (wr) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = addr;
            wr_data = wdata;
        end
        if (rd) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = addr;
        end
        if (oe)
            oe_cycles = oe_cycles + 1;
        if (wr && rd)
            both_cnt = both_cnt + 1;
        if ((wr && prev_wr) || (rd && prev_rd))
            long_cnt = long_cnt + 1;
        prev_wr = wr;
        prev_rd = rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One MDC period of 10 clocks; responder outputs are sampled late in the low phase.
    task automatic mdc_bit(input logic b);
        @(negedge clk);
        mdc  = 1'b0;
        mdio = b;
        repeat (4) @(negedge clk);
        s_out  = out;
        s_oe   = oe;
        s_busy = busy;
        mdc = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_header(input int pre, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] ra);
        for (int i = 0; i < pre; i++) mdc_bit(1'b1);
        mdc_bit(1'b0);
        mdc_bit(1'b1);
        mdc_bit(op[1]);
        mdc_bit(op[0]);
        for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i]);
    endtask

    task automatic write_tail(input logic [15:0] d);
        mdc_bit(1'b1);
        mdc_bit(1'b0);
        for (int i = 15; i >= 0; i--) mdc_bit(d[i]);
        mdc_bit(1'b1);
    endtask

    task automatic read_tail(output logic ta1_oe, output logic ta2_oe, output logic ta2_out,
                             output logic [15:0] d, output logic d_oe_all, output logic post_oe);
        mdc_bit(1'b1);
        ta1_oe = s_oe;
        mdc_bit(1'b1);
        ta2_oe  = s_oe;
        ta2_out = s_out;
        d_oe_all = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            mdc_bit(1'b1);
            d[i]     = s_out;
            d_oe_all = d_oe_all & s_oe;
        end
        mdc_bit(1'b1);
        post_oe = s_oe;
    endtask

    initial begin
        int w0, r0, o0;
        logic t1, t2, t2o, doe, poe;
        logic [15:0] d;

        for (int i = 0; i < 32; i++) regs[i] = 16'h0;
        regs[2] = 16'h1234;
        mdc  = 1'b0;
        mdio = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe", {31'd0, oe}, 32'd0);
        check("rst_out", {31'd0, out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_rd", {30'd0, wr, rd}, 32'd0);
        check("rst_addr", {27'd0, addr}, 32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write 0xBEEF to PHY 1 reg 3
        w0 = wr_cnt; o0 = oe_cycles;
        send_header(32, 2'b01, 5'd1, 5'd3);
        check("wr_busy_in_frame", {31'd0, s_busy}, 32'd1);
        write_tail(16'hBEEF);
        check("wr_count", wr_cnt - w0, 32'd1);
        check("wr_addr", {27'd0, wr_addr}, 32'd3);
        check("wr_data", {16'd0, wr_data}, 32'h0000BEEF);
        check("wr_no_oe", oe_cycles - o0, 32'd0);
        check("wr_busy_end", {31'd0, busy}, 32'd0);

        // Read PHY 1 reg 2 (0x1234)
        r0 = rd_cnt;
        send_header(32, 2'b10, 5'd1, 5'd2);
        read_tail(t1, t2, t2o, d, doe, poe);
        check("rd_count", rd_cnt - r0, 32'd1);
        check("rd_addr", {27'd0, rd_addr}, 32'd2);
        check("rd_ta1_oe", {31'd0, t1}, 32'd0);
        check("rd_ta2_oe", {31'd0, t2}, 32'd1);
        check("rd_ta2_out", {31'd0, t2o}, 32'd0);
        check("rd_data", {16'd0, d}, 32'h00001234);
        check("rd_data_oe", {31'd0, doe}, 32'd1);
        check("rd_post_oe", {31'd0, poe}, 32'd0);

        // Foreign PHYAD 5: silent tracking, then PHY 1 still decodes
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cycles;
        send_header(32, 2'b10, 5'd5, 5'd2);
        read_tail(t1, t2, t2o, d, doe, poe);
        send_header(32, 2'b01, 5'd5, 5'd4);
        write_tail(16'hA5A5);
        check("phy5_no_wr", wr_cnt - w0, 32'd0);
        check("phy5_no_rd", rd_cnt - r0, 32'd0);
        check("phy5_no_oe", oe_cycles - o0, 32'd0);
        send_header(32, 2'b01, 5'd1, 5'd7);
        write_tail(16'h1357);
        check("after_phy5_wr_count", wr_cnt - w0, 32'd1);
        check("after_phy5_wr_addr", {27'd0, wr_addr}, 32'd7);
        check("after_phy5_wr_data", {16'd0, wr_data}, 32'h00001357);

        // Short preamble (31 ones) ignored, full preamble accepted
        mdc_bit(1'b0);
        w0 = wr_cnt;
        send_header(31, 2'b01, 5'd1, 5'd3);
        write_tail(16'hBEEF);
        check("pre31_no_wr", wr_cnt - w0, 32'd0);
        send_header(32, 2'b01, 5'd1, 5'd4);
        write_tail(16'hCAFE);
        check("pre32_wr_count", wr_cnt - w0, 32'd1);
        check("pre32_wr_data", {16'd0, wr_data}, 32'h0000CAFE);

        // Illegal opcode 11 aborts
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 0; i < 32; i++) mdc_bit(1'b1);
        mdc_bit(1'b0);
        mdc_bit(1'b1);
        mdc_bit(1'b1);
        check("op11_busy_after_st", {31'd0, s_busy}, 32'd1);
        mdc_bit(1'b1);
        mdc_bit(1'b1);
        check("op11_busy_dropped", {31'd0, s_busy}, 32'd0);
        for (int i = 0; i < 10; i++) mdc_bit(1'b1);
        check("op11_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

        // Reset in the middle of read data
        send_header(32, 2'b10, 5'd1, 5'd2);
        mdc_bit(1'b1);
        mdc_bit(1'b1);
        for (int i = 0; i < 5; i++) mdc_bit(1'b1);
        check("mid_read_driving", {31'd0, s_oe}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_oe", {31'd0, oe}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = rd_cnt;
        send_header(32, 2'b10, 5'd1, 5'd2);
        read_tail(t1, t2, t2o, d, doe, poe);
        check("post_rst_rd_count", rd_cnt - r0, 32'd1);
        check("post_rst_rd_data", {16'd0, d}, 32'h00001234);
        check("post_rst_post_oe", {31'd0, poe}, 32'd0);

        // PHYAD 0: broadcast write only when enabled; reads never answered
        w0 = wr_cnt;
        send_header(32, 2'b01, 5'd0, 5'd5);
        write_tail(16'h00FF);
`ifdef MDIO_BCAST_EN
        check("bcast_wr_count", wr_cnt - w0, 32'd1);
        check("bcast_wr_data", {16'd0, wr_data}, 32'h000000FF);
`else
        check("phy0_no_wr", wr_cnt - w0, 32'd0);
`endif
        r0 = rd_cnt; o0 = oe_cycles;
        send_header(32, 2'b10, 5'd0, 5'd2);
        read_tail(t1, t2, t2o, d, doe, poe);
        check("phy0_rd_no_strobe", rd_cnt - r0, 32'd0);
        check("phy0_rd_no_oe", oe_cycles - o0, 32'd0);

        check("never_wr_and_rd", both_cnt, 32'd0);
        check("strobes_single_cycle", long_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
